// File: rtl/msp430_trace_buffer_if.sv
// Trace tap and readout bus for msp430_trace_buffer.
// The rd_data width follows TRACE_TIMESTAMP_EN: 49 bits when the macro is defined, otherwise 33 bits.
interface msp430_trace_buffer_if;
`ifdef TRACE_TIMESTAMP_EN
  localparam int RD_W = 49;
`else
  localparam int RD_W = 33;
`endif

  // Handshake: decode is a one-cycle strobe, and pc/ir/irq_detect are valid in the
  // same cycle. There is no backpressure on the tap. rd_en asks for the oldest entry.
  // An accepted read returns rd_data with a one-cycle rd_valid pulse on the next cycle.
  // A read that is not accepted leaves rd_valid low and rd_data unchanged.
  logic            decode;
  logic [15:0]     pc;
  logic [15:0]     ir;
  logic            irq_detect;
  logic            rd_en;
  logic [RD_W-1:0] rd_data;
  logic            rd_valid;

  modport master (
    output decode, pc, ir, irq_detect, rd_en,
    input  rd_data, rd_valid
  );

  modport slave (
    input  decode, pc, ir, irq_detect, rd_en,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/msp430_trace_buffer.sv
// Circular instruction-trace buffer with a PC-match trigger and a post-trigger freeze.
// Define TRACE_TIMESTAMP_EN to add a 16-bit inter-capture delta to each entry.
module msp430_trace_buffer #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  mclk,
  input  logic                  puc_rst,
  msp430_trace_buffer_if.slave  tif,
  input  logic                  trc_en,
  input  logic                  trc_clr,
  input  logic                  trig_en,
  input  logic [15:0]           trig_pc,
  input  logic [DEPTH_LOG2-1:0] post_cnt,
  output logic [DEPTH_LOG2:0]   entry_cnt,
  output logic [1:0]            trc_state,
  output logic                  triggered
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef TRACE_TIMESTAMP_EN
  localparam int ENT_W = 49;
`else
  localparam int ENT_W = 33;
`endif

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_POST   = 2'd2,
    S_FROZEN = 2'd3
  } state_t;

  state_t                state;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] post_ctr;
  logic [ENT_W-1:0]      mem [DEPTH];

  logic                  capture;
  logic                  trig_hit;
  logic                  rd_ok;
  logic [ENT_W-1:0]      new_entry;

  assign trc_state = state;

  assign capture  = trc_en && tif.decode && (state == S_ARMED || state == S_POST);
  assign trig_hit = tif.decode && trig_en && (tif.pc == trig_pc);

  // A read on the same edge that re-arms is refused, so re-arming discards what is left.
  assign rd_ok = tif.rd_en && (entry_cnt != '0) &&
                 (state == S_FROZEN || (state == S_IDLE && !trc_en));

`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] ts;
  logic [15:0] delta;

  // delta counts cycles including the capture cycle, and it saturates at 16'hFFFF.
  assign delta     = (ts == 16'hFFFF) ? 16'hFFFF : ts + 16'd1;
  assign new_entry = {delta, tif.irq_detect, tif.pc, tif.ir};
`else
  assign new_entry = {tif.irq_detect, tif.pc, tif.ir};
`endif

  always_ff @(posedge mclk) begin
    if (!puc_rst && !trc_clr && capture) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      entry_cnt    <= '0;
      post_ctr     <= '0;
      triggered    <= 1'b0;
      tif.rd_data  <= '0;
      tif.rd_valid <= 1'b0;
`ifdef TRACE_TIMESTAMP_EN
      ts           <= '0;
`endif
    end else if (trc_clr) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      entry_cnt    <= '0;
      triggered    <= 1'b0;
      tif.rd_valid <= 1'b0;
    end else begin
      tif.rd_valid <= 1'b0;
`ifdef TRACE_TIMESTAMP_EN
      if (capture) begin
        ts <= '0;
      end else if (ts != 16'hFFFF) begin
        ts <= ts + 16'd1;
      end
`endif

      if (rd_ok) begin
        tif.rd_data  <= mem[rd_ptr];
        tif.rd_valid <= 1'b1;
        rd_ptr       <= rd_ptr + PTR_ONE;
        entry_cnt    <= entry_cnt - CNT_ONE;
      end

      // When the buffer is full, the oldest entry is dropped by moving rd_ptr with wr_ptr.
      if (capture) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (entry_cnt != CNT_FULL) begin
          entry_cnt <= entry_cnt + CNT_ONE;
        end else begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
      end

      case (state)
        S_IDLE: begin
          if (trc_en) begin
            state     <= S_ARMED;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            entry_cnt <= '0;
            post_ctr  <= '0;
            triggered <= 1'b0;
`ifdef TRACE_TIMESTAMP_EN
            ts        <= '0;
`endif
          end
        end
        S_ARMED: begin
          if (!trc_en) begin
            state <= S_IDLE;
          end else if (capture && trig_hit) begin
            triggered <= 1'b1;
            if (post_cnt == '0) begin
              state <= S_FROZEN;
            end else begin
              state    <= S_POST;
              post_ctr <= post_cnt;
            end
          end
        end
        S_POST: begin
          if (!trc_en) begin
            state <= S_IDLE;
          end else if (capture) begin
            post_ctr <= post_ctr - PTR_ONE;
            if (post_ctr == PTR_ONE) begin
              state <= S_FROZEN;
            end
          end
        end
        S_FROZEN: begin
          if (!trc_en) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/msp430_trace_buffer.md
Name: msp430_trace_buffer

Overview:
Instruction trace capture stage that sits directly downstream of the core's decode/IR/PC debug taps, the same signals the execution monitor consumes. On every decode pulse it records {irq flag, PC, opcode} into a circular buffer. It supports PC-match triggering with a programmable post-trigger depth, after which the buffer freezes. Captured entries are drained oldest-first through a simple read port for bench inspection or debug-unit readout.

Parameters:
DEPTH_LOG2, 4, log2 of buffer entries (DEPTH = 16)

Ports:
mclk  input  1  main system clock
puc_rst  input  1  synchronous active-high reset
decode  input  1  one-cycle pulse; new instruction decoded this cycle
pc  input  16  PC of the decoded instruction, valid with decode
ir  input  16  opcode of the decoded instruction, valid with decode
irq_detect  input  1  decode is an interrupt entry, valid with decode
trc_en  input  1  level; arm/run trace
trc_clr  input  1  pulse; clear buffer, return to IDLE
trig_en  input  1  enable PC-match trigger
trig_pc  input  16  trigger PC value
post_cnt  input  DEPTH_LOG2  entries captured after the trigger entry
rd_en  input  1  pop oldest entry
rd_data  output  33 (49 with timestamp)  {irq, pc, ir} or {delta, irq, pc, ir}, MSB first
rd_valid  output  1  rd_data valid, one-cycle pulse
entry_cnt  output  DEPTH_LOG2+1  stored entries, 0..DEPTH
trc_state  output  2  0 IDLE, 1 ARMED, 2 POST, 3 FROZEN
triggered  output  1  sticky; trigger seen since last arm/clear

Behaviour:
- Reset (sync, puc_rst=1 at mclk edge): trc_state=IDLE, entry_cnt=0, wr/rd pointers=0, rd_data=0, rd_valid=0, triggered=0, post counter=0, timestamp counter=0.
- Priority: puc_rst > trc_clr > state transitions > capture/read.
- trc_clr: pointers=0, entry_cnt=0, triggered=0, state=IDLE, rd_valid=0.
- IDLE: no capture. trc_en=1 -> ARMED. Pointers and count clear on the same edge.
- ARMED: every decode writes an entry at wr_ptr, and wr_ptr increments modulo DEPTH.
  - If entry_cnt<DEPTH, it increments.
  - If full, the oldest entry is overwritten and rd_ptr advances with wr_ptr. entry_cnt stays at DEPTH.
  - Trigger = decode & trig_en & (pc==trig_pc). The triggering instruction is captured and triggered is set.
  - On trigger with post_cnt==0, go to FROZEN. Otherwise go to POST and load the counter with post_cnt.
  - trc_en=0 -> IDLE. The buffer is retained and readable.
- POST: captures as in ARMED. Each decode decrements the counter. When a capture happens with counter==1, go to FROZEN on that edge. Further triggers are ignored. trc_en=0 -> IDLE.
- FROZEN: no capture. trc_en=0 -> IDLE. trc_en stays 1 -> remain FROZEN.
- Read: accepted only in IDLE or FROZEN with entry_cnt>0.
  - Next cycle: rd_data = entry[rd_ptr], rd_valid=1.
  - rd_ptr increments modulo DEPTH and entry_cnt decrements.
  - rd_en when empty or in ARMED/POST: ignored, rd_valid=0, rd_data holds.
- Read latency is 1 cycle. Back-to-back rd_en drains one entry per cycle.
- rd_valid is 0 on any cycle without an accepted read.
- Entering ARMED from IDLE discards unread entries.

Optional Feature:
TRACE_TIMESTAMP_EN.
- Defined:
  - A 16-bit cycle counter increments every mclk and saturates at 16'hFFFF.
  - On each capture, the counter value is stored as field delta, and the counter restarts at 1 on that edge.
  - The counter is cleared on entry to ARMED.
  - rd_data is 49 bits, {delta[15:0], irq, pc, ir}.
- Undefined: no counter is present and rd_data is 33 bits.

Test Plan:
1. Reset, then trc_en=1. Issue 5 decodes with pc=0xF000+2n, ir=0x4303, irq=0. Then trc_en=0 and read 5 times -> rd_data pc sequence F000,F002,F004,F006,F008; entry_cnt 5->0; a 6th rd_en gives rd_valid=0.
2. Wrap: 20 decodes with pc=n (0..19), DEPTH=16 -> entry_cnt=16; reads return pc 4..19 in order.
3. Trigger: trig_en=1, trig_pc=0xF010, post_cnt=3, decodes with pc=0xF000..0xF01E step 2 -> FROZEN after capture of 0xF016; triggered=1; the last 4 entries are F010,F012,F014,F016; later decodes are not captured.
4. post_cnt=0 with trigger at 0xF004 -> FROZEN on the same edge; newest entry is F004.
5. trc_clr pulsed together with rd_en in FROZEN, entry_cnt=8 -> state IDLE, entry_cnt=0, triggered=0, rd_valid=0. Also assert puc_rst during POST -> all outputs return to reset values on the next edge.
6. With TRACE_TIMESTAMP_EN: decodes at cycles 0, 3, 10 after arm -> deltas 1, 3, 7. A gap >65535 cycles -> delta=0xFFFF.
